// File: rtl/UART_pkg.sv
// UART CSR package: address map, status bit positions, CSR field layouts and
// commit FSM states shared by the CSR controller and its interface.
package UART_pkg;

  localparam int unsigned UART_BAUD_ADDR   = 0;
  localparam int unsigned UART_CTRL_ADDR   = 1;
  localparam int unsigned UART_STATUS_ADDR = 2;

  localparam int unsigned UART_STAT_PERR_BIT = 0;
  localparam int unsigned UART_STAT_BUSY_BIT = 1;
  localparam int unsigned UART_STAT_FREE_BIT = 2;
  localparam int unsigned UART_STAT_PEND_BIT = 3;
  localparam int unsigned UART_STAT_TMO_BIT  = 4;

  localparam int unsigned UART_BAUD_W = 16;
  localparam int unsigned UART_CTRL_W = 5;

  typedef struct packed {
    logic [UART_BAUD_W-1:0] divisor;
  } uart_baud_rate_csr_t;

  typedef struct packed {
    logic two_stop;
    logic parity_odd;
    logic parity_en;
    logic rx_en;
    logic tx_en;
  } uart_control_0_csr_t;

  typedef struct packed {
    logic cfg_timeout;
    logic cfg_pending;
    logic free;
    logic busy;
    logic parity_err;
  } uart_status_0_csr_t;

  typedef enum logic {
    CMT_IDLE = 1'b0,
    CMT_PEND = 1'b1
  } uart_csr_cmt_state_t;

endpackage

// File: rtl/UART_csr_if.sv
// UART CSR interface: live configuration and status toward the UART core,
// line status back from it.
interface UART_csr_if;
  import UART_pkg::*;

  uart_baud_rate_csr_t uart_baud_rate_csr;
  uart_control_0_csr_t uart_control_0_csr;
  uart_status_0_csr_t  uart_status_0_csr;
  logic                parity_error;
  logic                busy;
  logic                free;

  modport csr_mp (
    output uart_baud_rate_csr,
    output uart_control_0_csr,
    output uart_status_0_csr,
    input  parity_error,
    input  busy,
    input  free
  );

  modport uart_mp (
    input  uart_baud_rate_csr,
    input  uart_control_0_csr,
    input  uart_status_0_csr,
    output parity_error,
    output busy,
    output free
  );

endinterface

// File: rtl/uart_csr_commit_fsm.sv
// Shadow-to-live commit sequencer. With UART_CSR_TIMEOUT_EN defined, a pending
// commit is forced after TIMEOUT_CYCLES cycles even if the UART never goes free.
module uart_csr_commit_fsm
  import UART_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_cfg_i,
  input  logic ready_i,
  output logic commit_o,
  output logic pending_d_o,
  output logic timeout_o
);

  uart_csr_cmt_state_t state_q, state_d;
  logic                force_commit;

`ifdef UART_CSR_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  assign force_commit = (state_q == CMT_PEND) && (cnt_q == TMO_LAST);

  // Counts only while waiting; any shadow write or commit restarts it.
  always_comb begin
    cnt_d = '0;
    if (state_q == CMT_PEND && !wr_cfg_i && !commit_o) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unsigned unused_tmo = TIMEOUT_CYCLES;

  assign force_commit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    commit_o  = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      CMT_IDLE: begin
        if (wr_cfg_i) state_d = CMT_PEND;
      end
      CMT_PEND: begin
        commit_o  = ready_i | force_commit;
        timeout_o = force_commit & ~ready_i;
        if (wr_cfg_i) begin
          state_d = CMT_PEND;
        end else if (commit_o) begin
          state_d = CMT_IDLE;
        end
      end
      default: state_d = CMT_IDLE;
    endcase
  end

  assign pending_d_o = (state_d == CMT_PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CMT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/uart_csr_ctrl.sv
// UART CSR register-bus slave: shadowed baud/control with commit-when-free,
// sticky parity error, one-cycle ack. Optional forced commit: UART_CSR_TIMEOUT_EN.
module uart_csr_ctrl
  import UART_pkg::*;
#(
  parameter int unsigned ADDR_W         = 2,
  parameter int unsigned DATA_W         = 32,
  parameter logic [15:0] BAUD_RST       = 16'd434,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csr_req,
  input  logic              csr_we,
  input  logic [ADDR_W-1:0] csr_addr,
  input  logic [DATA_W-1:0] csr_wdata,
  output logic [DATA_W-1:0] csr_rdata,
  output logic              csr_ack,
  output logic              csr_err,
  UART_csr_if.csr_mp        csr_if
);

  logic accept;
  logic sel_baud, sel_ctrl, sel_stat, sel_rsvd;
  logic wr_baud, wr_ctrl, wr_stat;
  logic clr_perr, clr_tmo;
  logic commit, pending_d, tmo_fire;
  logic unused_wdata;

  uart_baud_rate_csr_t baud_q, baud_d, baud_sh_q, baud_sh_d;
  uart_control_0_csr_t ctrl_q, ctrl_d, ctrl_sh_q, ctrl_sh_d;
  uart_status_0_csr_t  status_q, status_d;

  logic              ack_q, err_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign accept   = csr_req & ~ack_q;
  assign sel_baud = (csr_addr == ADDR_W'(UART_BAUD_ADDR));
  assign sel_ctrl = (csr_addr == ADDR_W'(UART_CTRL_ADDR));
  assign sel_stat = (csr_addr == ADDR_W'(UART_STATUS_ADDR));
  assign sel_rsvd = ~(sel_baud | sel_ctrl | sel_stat);

  assign wr_baud  = accept & csr_we & sel_baud;
  assign wr_ctrl  = accept & csr_we & sel_ctrl;
  assign wr_stat  = accept & csr_we & sel_stat;
  assign clr_perr = wr_stat & csr_wdata[UART_STAT_PERR_BIT];
  assign clr_tmo  = wr_stat & csr_wdata[UART_STAT_TMO_BIT];

  assign unused_wdata = ^csr_wdata[DATA_W-1:UART_BAUD_W];

  uart_csr_commit_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_commit (
    .clk        (clk),
    .rst        (rst),
    .wr_cfg_i   (wr_baud | wr_ctrl),
    .ready_i    (csr_if.free & ~csr_if.busy),
    .commit_o   (commit),
    .pending_d_o(pending_d),
    .timeout_o  (tmo_fire)
  );

  // Live copies take the pre-write shadow; a write in the commit cycle stays pending.
  always_comb begin
    baud_d    = commit ? baud_sh_q : baud_q;
    ctrl_d    = commit ? ctrl_sh_q : ctrl_q;
    baud_sh_d = baud_sh_q;
    ctrl_sh_d = ctrl_sh_q;
    if (wr_baud) baud_sh_d = uart_baud_rate_csr_t'(csr_wdata[UART_BAUD_W-1:0]);
    if (wr_ctrl) ctrl_sh_d = uart_control_0_csr_t'(csr_wdata[UART_CTRL_W-1:0]);
  end

  always_comb begin
    status_d             = '0;
    status_d.parity_err  = csr_if.parity_error | (status_q.parity_err & ~clr_perr);
    status_d.busy        = csr_if.busy;
    status_d.free        = csr_if.free;
    status_d.cfg_pending = pending_d;
    status_d.cfg_timeout = tmo_fire | (status_q.cfg_timeout & ~clr_tmo);
  end

  always_comb begin
    rdata_d = '0;
    if (accept && !csr_we) begin
      if (sel_baud) begin
        rdata_d = DATA_W'(baud_sh_q);
      end else if (sel_ctrl) begin
        rdata_d = DATA_W'(ctrl_sh_q);
      end else if (sel_stat) begin
        rdata_d = DATA_W'(status_d);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      baud_q    <= uart_baud_rate_csr_t'(BAUD_RST);
      ctrl_q    <= '0;
      baud_sh_q <= uart_baud_rate_csr_t'(BAUD_RST);
      ctrl_sh_q <= '0;
      status_q  <= '0;
    end else begin
      ack_q     <= accept;
      err_q     <= accept & sel_rsvd;
      rdata_q   <= rdata_d;
      baud_q    <= baud_d;
      ctrl_q    <= ctrl_d;
      baud_sh_q <= baud_sh_d;
      ctrl_sh_q <= ctrl_sh_d;
      status_q  <= status_d;
    end
  end

  assign csr_ack   = ack_q;
  assign csr_err   = err_q;
  assign csr_rdata = rdata_q;

  assign csr_if.uart_baud_rate_csr = baud_q;
  assign csr_if.uart_control_0_csr = ctrl_q;
  assign csr_if.uart_status_0_csr  = status_q;

endmodule

// File: tb/tb_uart_csr_ctrl.sv
// Self-checking bench for uart_csr_ctrl: directed test-plan sequences followed
// by randomized traffic, all checked against a transaction-level model.
module tb_uart_csr_ctrl;
  import UART_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_req, csr_we;
  logic [1:0]  csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_ack, csr_err;

  UART_csr_if uif();

  uart_csr_ctrl #(
    .ADDR_W        (2),
    .DATA_W        (32),
    .BAUD_RST      (16'd434),
    .TIMEOUT_CYCLES(65535)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .csr_req  (csr_req),
    .csr_we   (csr_we),
    .csr_addr (csr_addr),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .csr_ack  (csr_ack),
    .csr_err  (csr_err),
    .csr_if   (uif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural view of the CSR block.
  logic [31:0] m_live_baud, m_live_ctrl, m_sh_baud, m_sh_ctrl, m_rdata, m_status;
  bit          m_pend, m_perr, m_ack, m_err, last_acc;

  function automatic logic [31:0] status_word(input bit fr, input bit bz);
    return {27'd0, 1'b0, m_pend, fr, bz, m_perr};
  endfunction

  task automatic model_reset();
    m_live_baud = 32'd434;
    m_live_ctrl = 32'd0;
    m_sh_baud   = 32'd434;
    m_sh_ctrl   = 32'd0;
    m_pend      = 1'b0;
    m_perr      = 1'b0;
    m_ack       = 1'b0;
    m_err       = 1'b0;
    m_rdata     = 32'd0;
    m_status    = 32'd0;
    last_acc    = 1'b0;
  endtask

  task automatic check_live(input string sfx);
    check({"live_baud", sfx}, 32'(uif.uart_baud_rate_csr), m_live_baud);
    check({"live_ctrl", sfx}, 32'(uif.uart_control_0_csr), m_live_ctrl);
    check({"status", sfx}, 32'(uif.uart_status_0_csr), m_status);
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic step(input bit req, input bit we, input logic [1:0] addr,
                      input logic [31:0] wd, input bit fr, input bit bz, input bit pe);
    bit acc, cmt, cfgw;
    csr_req          = req;
    csr_we           = we;
    csr_addr         = addr;
    csr_wdata        = wd;
    uif.free         = fr;
    uif.busy         = bz;
    uif.parity_error = pe;

    acc  = req && !m_ack;
    cmt  = m_pend && fr && !bz;
    cfgw = acc && we && (addr == 2'd0 || addr == 2'd1);
    if (cmt) begin
      m_live_baud = m_sh_baud;
      m_live_ctrl = m_sh_ctrl;
    end
    m_rdata = 32'd0;
    if (acc && !we) begin
      if (addr == 2'd0) m_rdata = m_sh_baud;
      else if (addr == 2'd1) m_rdata = m_sh_ctrl;
    end
    if (acc && we) begin
      if (addr == 2'd0) m_sh_baud = wd & 32'h0000_FFFF;
      else if (addr == 2'd1) m_sh_ctrl = wd & 32'h0000_001F;
      else if (addr == 2'd2 && wd[0]) m_perr = 1'b0;
    end
    if (cfgw) m_pend = 1'b1;
    else if (cmt) m_pend = 1'b0;
    if (pe) m_perr = 1'b1;
    m_status = status_word(fr, bz);
    if (acc && !we && addr == 2'd2) m_rdata = m_status;
    m_err    = acc && (addr == 2'd3);
    m_ack    = acc;
    last_acc = acc;

    @(posedge clk);
    #1;
    check("ack", 32'(csr_ack), 32'(m_ack));
    check("err", 32'(csr_err), 32'(m_err));
    if (m_ack) check("rdata", csr_rdata, m_rdata);
    check_live("");
  endtask

  task automatic idle(input bit fr, input bit bz, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 2'd0, 32'd0, fr, bz, 1'b0);
  endtask

  bit          r_req, r_we, r_bz, r_fr, r_pe;
  logic [1:0]  r_addr;
  logic [31:0] r_wd;

  initial begin
    rst              = 1'b1;
    csr_req          = 1'b0;
    csr_we           = 1'b0;
    csr_addr         = 2'd0;
    csr_wdata        = 32'd0;
    uif.free         = 1'b1;
    uif.busy         = 1'b0;
    uif.parity_error = 1'b0;
    model_reset();
    #1;
    check("rst_ack", 32'(csr_ack), 32'd0);
    check("rst_err", 32'(csr_err), 32'd0);
    check("rst_rdata", csr_rdata, 32'd0);
    check_live("_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values read back through the bus
    step(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 2'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 2'd2, 32'd0, 1'b1, 1'b0, 1'b0);
    check("status_read_reset", csr_rdata, 32'h4);
    idle(1'b1, 1'b0, 1);

    // Immediate commit while free
    step(1'b1, 1'b1, 2'd0, 32'h0000_01B2, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 2);
    check("baud_committed", 32'(uif.uart_baud_rate_csr), 32'h1B2);

    // Writes held off while the UART is busy
    step(1'b1, 1'b1, 2'd1, 32'h0000_001F, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 1);
    step(1'b1, 1'b1, 2'd1, 32'hFFFF_FF03, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 5);
    check("ctrl_held", 32'(uif.uart_control_0_csr), 32'h0);
    idle(1'b1, 1'b0, 2);
    check("ctrl_committed", 32'(uif.uart_control_0_csr), 32'h3);

    // Sticky parity error and W1C priority
    step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0, 2);
    step(1'b1, 1'b1, 2'd2, 32'h1, 1'b1, 1'b0, 1'b1);
    idle(1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 2'd2, 32'h1, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1);

    // Reserved address
    step(1'b1, 1'b0, 2'd3, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1);

    // A long busy stretch never commits without the forced-commit option
    step(1'b1, 1'b1, 2'd0, 32'h0000_0010, 1'b0, 1'b1, 1'b0);
    idle(1'b0, 1'b1, 40);
    check("no_forced_commit", 32'(uif.uart_baud_rate_csr), 32'h1B2);

    // Asynchronous reset while a commit is pending
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_baud", 32'(uif.uart_baud_rate_csr), 32'd434);
    check("arst_status", 32'(uif.uart_status_0_csr), 32'd0);
    check("arst_ack", 32'(csr_ack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 2);

    // Randomized traffic with alternating busy-heavy and free-heavy phases
    r_req = 1'b0;
    r_we  = 1'b0;
    r_addr = 2'd0;
    r_wd  = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!(r_req && !last_acc)) begin
        r_req  = ($urandom_range(0, 2) != 0);
        r_we   = $urandom_range(0, 1) == 1;
        r_addr = 2'($urandom_range(0, 3));
        r_wd   = $urandom;
      end
      if ((i % 400) < 200) r_bz = ($urandom_range(0, 3) == 0);
      else r_bz = ($urandom_range(0, 9) != 0);
      r_fr = r_bz ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
      r_pe = ($urandom_range(0, 15) == 0);
      step(r_req, r_we, r_addr, r_wd, r_fr, r_bz, r_pe);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
